// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared constants for the 5-stage ARM pipeline: datapath width,
//                reset PC, the NOP encoding used for flushed slots and the PC
//                increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // Register-file address length (16 architectural registers).
    localparam int unsigned c_REGFILE_ADDR_LEN = 4;

    localparam int unsigned c_WORD_LEN = 32;

    localparam logic [c_WORD_LEN-1:0] c_RESET_PC     = 32'h0000_0000;
    localparam logic [c_WORD_LEN-1:0] c_NOP_INSTR    = 32'h0000_0000;
    localparam logic [c_WORD_LEN-1:0] c_PC_INCREMENT = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : Pipeline register carrying {pc, instr, valid}. Priority is
//                rst > flush > freeze > load. Reset and flush both insert a
//                bubble (zero pc, NOP instruction, valid low); freeze holds
//                every field, valid included.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_flush        - squash contents into a bubble
//                i_freeze       - hold contents
//                i_pc/i_instr/i_valid - next contents on a normal load
//                o_pc/o_instr/o_valid - registered contents
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DATA_W = c_WORD_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_freeze,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_instr,
    input  logic              i_valid,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pc    <= '0;
            r_instr <= DATA_W'(c_NOP_INSTR);
            r_valid <= 1'b0;
        end else if (!i_freeze) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= i_valid;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage: PC register, PC+4 incrementer,
//                branch-target mux, IF/ID pipeline register and a saturating
//                count of hazard-stall cycles.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                freeze          - hazard stall: hold PC and IF/ID
//                branch_taken    - EXE redirect (wins over freeze)
//                branch_addr     - redirect target (low 2 bits ignored)
//                imem_addr       - instruction address (= PC, combinational)
//                imem_rdata      - asynchronous instruction memory data
//                if_id_pc/instr/valid - IF/ID register contents
//                stall_count     - saturating count of freeze cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          WORD_LEN    = c_WORD_LEN,
    parameter logic [WORD_LEN-1:0]  RESET_PC    = c_RESET_PC,
    parameter int unsigned          STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [WORD_LEN-1:0]    branch_addr,
    output logic [WORD_LEN-1:0]    imem_addr,
    input  logic [WORD_LEN-1:0]    imem_rdata,
    output logic [WORD_LEN-1:0]    if_id_pc,
    output logic [WORD_LEN-1:0]    if_id_instr,
    output logic                   if_id_valid,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [WORD_LEN-1:0]    r_pc;
    logic [WORD_LEN-1:0]    w_pc_plus4;
    logic [WORD_LEN-1:0]    w_branch_target;
    logic [WORD_LEN-1:0]    w_pc_next;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_stall_cycle;

    // Natural wrap of the adder gives the required modulo-2^WORD_LEN behaviour.
    assign w_pc_plus4      = r_pc + WORD_LEN'(c_PC_INCREMENT);
    assign w_branch_target = branch_addr & ~WORD_LEN'(3);

    // A redirect in the same cycle as a hazard is not a stall: the held
    // instruction in ID is wrong-path and gets flushed anyway.
    assign w_stall_cycle = freeze && !branch_taken;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (branch_taken) begin
            w_pc_next = w_branch_target;
        end else if (freeze) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_cycle && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    if_id_reg #(
        .DATA_W (WORD_LEN)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (branch_taken),
        .i_freeze (freeze),
        .i_pc     (w_pc_plus4),
        .i_instr  (imem_rdata),
        .i_valid  (1'b1),
        .o_pc     (if_id_pc),
        .o_instr  (if_id_instr),
        .o_valid  (if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage with a behavioural model
//                of the fetch rules, directed scenarios pinned by literal
//                expectations, then randomized freeze/branch/reset traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int unsigned c_W   = 32;
    localparam int unsigned c_SCW = 4;
    localparam int          c_SAT = (1 << c_SCW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             freeze = 1'b0;
    logic             branch_taken = 1'b0;
    logic [c_W-1:0]   branch_addr = '0;
    wire  [c_W-1:0]   imem_addr;
    wire  [c_W-1:0]   imem_rdata;
    wire  [c_W-1:0]   if_id_pc;
    wire  [c_W-1:0]   if_id_instr;
    wire              if_id_valid;
    wire  [c_SCW-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state.
    logic [c_W-1:0] m_pc;
    logic [c_W-1:0] m_ipc;
    logic [c_W-1:0] m_instr;
    logic           m_valid;
    int             m_cnt;
    bit             m_known = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory image: the word at address A encodes A's low half.
    function automatic logic [c_W-1:0] mem_word(input logic [c_W-1:0] a);
        return {8'hE0, 8'h00, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_stage #(
        .WORD_LEN    (c_W),
        .RESET_PC    (32'h0000_0000),
        .STALL_CNT_W (c_SCW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .if_id_valid  (if_id_valid),
        .stall_count  (stall_count)
    );

    task automatic chk(input string name, input logic [c_W-1:0] act,
                       input logic [c_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what one clock edge does to the fetch state.
    always @(posedge clk) begin
        if (rst) begin
            m_pc    = 32'h0;
            m_ipc   = 32'h0;
            m_instr = 32'h0;
            m_valid = 1'b0;
            m_cnt   = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (branch_taken) begin
                m_pc    = (branch_addr / 4) * 4;
                m_ipc   = 32'h0;
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else if (freeze) begin
                m_cnt = (m_cnt + 1 > c_SAT) ? c_SAT : m_cnt + 1;
            end else begin
                m_ipc   = m_pc + 32'd4;
                m_instr = mem_word(m_pc);
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_known) begin
            chk("imem_addr",   imem_addr,   m_pc);
            chk("if_id_pc",    if_id_pc,    m_ipc);
            chk("if_id_instr", if_id_instr, m_instr);
            chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            chk("stall_count", {28'b0, stall_count}, 32'(m_cnt));
        end
    end

    // Apply inputs for one edge, then return at the following negedge.
    task automatic drive(input logic r, input logic f, input logic b,
                         input logic [c_W-1:0] a);
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = a;
        @(negedge clk);
    endtask

    initial begin
        // Reset.
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("rst_pc",    imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_ifpc",  if_id_pc, 32'h0);
        chk("rst_cnt",   {28'b0, stall_count}, 32'h0);

        // Free-run.
        drive(0, 0, 0, 0);
        chk("run_pc1",    imem_addr, 32'h4);
        chk("run_ifpc1",  if_id_pc, 32'h4);
        chk("run_valid1", {31'b0, if_id_valid}, 32'h1);
        chk("run_instr1", if_id_instr, 32'hE000_0000);
        drive(0, 0, 0, 0);
        chk("run_pc2",   imem_addr, 32'h8);
        chk("run_ifpc2", if_id_pc, 32'h8);

        // Three freeze cycles at pc = 8.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            chk("frz_pc",   imem_addr, 32'h8);
            chk("frz_ifpc", if_id_pc, 32'h8);
        end
        chk("frz_cnt", {28'b0, stall_count}, 32'd3);
        drive(0, 0, 0, 0);
        chk("rel_ifpc",  if_id_pc, 32'hC);
        chk("rel_instr", if_id_instr, 32'hE000_0008);
        drive(0, 0, 0, 0);
        chk("rel_pc", imem_addr, 32'h10);

        // Branch at pc = 0x10.
        drive(0, 0, 1, 32'h100);
        chk("br_pc",    imem_addr, 32'h100);
        chk("br_valid", {31'b0, if_id_valid}, 32'h0);
        chk("br_instr", if_id_instr, 32'h0);
        drive(0, 0, 0, 0);
        chk("br_ifpc2",  if_id_pc, 32'h104);
        chk("br_valid2", {31'b0, if_id_valid}, 32'h1);

        // Branch and freeze together, unaligned target.
        drive(0, 1, 1, 32'h203);
        chk("bf_pc",    imem_addr, 32'h200);
        chk("bf_valid", {31'b0, if_id_valid}, 32'h0);
        chk("bf_cnt",   {28'b0, stall_count}, 32'd3);

        // PC wrap.
        drive(0, 0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0);
        chk("wrap_pc",    imem_addr, 32'h0);
        chk("wrap_ifpc",  if_id_pc, 32'h0);
        chk("wrap_instr", if_id_instr, 32'hE000_FFFC);

        // Saturation.
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0);
        chk("sat_cnt", {28'b0, stall_count}, 32'd15);

        // Reset in the middle of a freeze.
        drive(1, 1, 0, 0);
        chk("rstf_pc",    imem_addr, 32'h0);
        chk("rstf_ifpc",  if_id_pc, 32'h0);
        chk("rstf_instr", if_id_instr, 32'h0);
        chk("rstf_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rstf_cnt",   {28'b0, stall_count}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic r, f, b;
            logic [c_W-1:0] a;
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 35);
            b = ($urandom_range(0, 99) < 10);
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            drive(r, f, b, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
